// File: rtl/json_feed_sequencer.sv
// Feeds one JSON document from BRAM to the parser core byte by byte and
// reports how parsing ended along with the number of bytes the parser took.
module json_feed_sequencer #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned LEN_W         = 16,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  doc_len,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [LEN_W-1:0]  bytes_consumed,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              par_rst,
  output logic [7:0]        par_byte,
  output logic              par_valid,
  input  logic              par_ready,
  input  logic              par_doc_end,
  input  logic              par_error
);

  localparam int unsigned TMR_W = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_PARSE_ERR = 2'd1;
  localparam logic [1:0] ST_TRUNC     = 2'd2;
  localparam logic [1:0] ST_ABORT     = 2'd3;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} seqStateT;

  seqStateT          state;
  logic [ADDR_W-1:0] baseAddr;
  logic [LEN_W-1:0]  docLen;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  xferCnt;
  logic [TMR_W-1:0]  drainCnt;
  logic              inFlight;
  logic              tailValid;
  logic [7:0]        tailByte;

  logic              xferNow;
  logic [LEN_W-1:0]  xferNext;
  logic [2:0]        pending;
  logic              termNow;
  logic [1:0]        termStatus;
  logic              headValidNext;
  logic [7:0]        headByteNext;
  logic              tailValidNext;
  logic [7:0]        tailByteNext;

  assign xferNow  = par_valid && par_ready;
  assign xferNext = xferCnt + LEN_W'(xferNow);
  assign pending  = 3'(par_valid) + 3'(tailValid) + 3'(inFlight);

  // Read issue counts this cycle's pop as free space, so two entries sustain 1 byte/cycle.
  assign mem_en   = (state == STREAM) && (issued < docLen) && (pending < (3'd2 + 3'(xferNow)));
  assign mem_addr = mem_en ? (baseAddr + ADDR_W'(issued)) : '0;

  // Two-entry FIFO: head is the par_byte/par_valid register, tail sits behind it.
  always_comb begin
    headValidNext = par_valid;
    headByteNext  = par_byte;
    tailValidNext = tailValid;
    tailByteNext  = tailByte;
    if (xferNow) begin
      headValidNext = tailValid || inFlight;
      headByteNext  = tailValid ? tailByte : mem_data;
      tailValidNext = tailValid && inFlight;
      tailByteNext  = mem_data;
    end else if (inFlight) begin
      if (!par_valid) begin
        headValidNext = 1'b1;
        headByteNext  = mem_data;
      end else begin
        tailValidNext = 1'b1;
        tailByteNext  = mem_data;
      end
    end
  end

  // Termination priority: abort, parser error, document end, drain timeout.
  always_comb begin
    termNow    = 1'b0;
    termStatus = ST_OK;
    if (state == CLEAR || state == STREAM || state == DRAIN) begin
      if (abort) begin
        termNow    = 1'b1;
        termStatus = ST_ABORT;
      end else if (par_error) begin
        termNow    = 1'b1;
        termStatus = ST_PARSE_ERR;
      end else if (par_doc_end) begin
        termNow    = 1'b1;
        termStatus = ST_OK;
      end else if (state == DRAIN && drainCnt == TMR_W'(DRAIN_TIMEOUT - 1)) begin
        termNow    = 1'b1;
        termStatus = ST_TRUNC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      status         <= ST_OK;
      bytes_consumed <= '0;
      par_rst        <= 1'b0;
      par_valid      <= 1'b0;
      par_byte       <= '0;
      baseAddr       <= '0;
      docLen         <= '0;
      issued         <= '0;
      xferCnt        <= '0;
      drainCnt       <= '0;
      inFlight       <= 1'b0;
      tailValid      <= 1'b0;
      tailByte       <= '0;
    end else begin
      par_rst <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            baseAddr       <= base_addr;
            docLen         <= doc_len;
            issued         <= '0;
            xferCnt        <= '0;
            drainCnt       <= '0;
            busy           <= 1'b1;
            status         <= ST_OK;
            bytes_consumed <= '0;
            if (doc_len == '0) begin
              state  <= DONE;
              done   <= 1'b1;
              status <= ST_TRUNC;
            end else begin
              state   <= CLEAR;
              par_rst <= 1'b1;
            end
          end
        end
        CLEAR, STREAM, DRAIN: begin
          if (termNow) begin
            // Flush the FIFO and drop any read still returning.
            state          <= DONE;
            done           <= 1'b1;
            status         <= termStatus;
            bytes_consumed <= xferNext;
            par_valid      <= 1'b0;
            tailValid      <= 1'b0;
            inFlight       <= 1'b0;
          end else begin
            xferCnt   <= xferNext;
            issued    <= issued + LEN_W'(mem_en);
            inFlight  <= mem_en;
            par_valid <= headValidNext;
            par_byte  <= headByteNext;
            tailValid <= tailValidNext;
            tailByte  <= tailByteNext;
            if (state == CLEAR) begin
              state <= STREAM;
            end else if (state == STREAM && xferNext == docLen) begin
              state    <= DRAIN;
              drainCnt <= TMR_W'(1);
            end else if (state == DRAIN) begin
              drainCnt <= drainCnt + TMR_W'(1);
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_json_feed_sequencer.sv
// Bench for json_feed_sequencer: BRAM and parser models around the DUT, with
// expected bytes taken from the memory image and status from each scenario.
module tb_json_feed_sequencer;

  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned LEN_W         = 16;
  localparam int unsigned DRAIN_TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  doc_len;
  logic              busy;
  logic              done;
  logic [1:0]        status;
  logic [LEN_W-1:0]  bytes_consumed;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = 8'h00;
  logic              par_rst;
  logic [7:0]        par_byte;
  logic              par_valid;
  logic              par_ready;
  logic              par_doc_end;
  logic              par_error;

  logic [7:0] memArr [0:65535];
  int total = 0;
  int bad   = 0;
  int doneCnt;

  json_feed_sequencer #(
    .ADDR_W(ADDR_W),
    .LEN_W(LEN_W),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .base_addr(base_addr),
    .doc_len(doc_len),
    .busy(busy),
    .done(done),
    .status(status),
    .bytes_consumed(bytes_consumed),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .par_rst(par_rst),
    .par_byte(par_byte),
    .par_valid(par_valid),
    .par_ready(par_ready),
    .par_doc_end(par_doc_end),
    .par_error(par_error)
  );

  always #5 clk = ~clk;

  // BRAM with one cycle of read latency
  always @(posedge clk) if (mem_en) mem_data <= memArr[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // mode: 0 doc_end after n-th transfer, 1 error after n-th transfer,
  //       2 abort during n-th transfer, 3 parser never finishes
  // readyMode: 0 always ready, 1 toggling 1-0, 2 random
  task automatic runDoc(input logic [15:0] b, input logic [15:0] l, input int mode, input int n,
                        input int readyMode, input bit busyStart, input bit abortWithStart);
    int xfers, issues, rstCnt, cyc, lastX, doneCyc;
    bit flagPend, holdPend, doneSeen, xferNow, pr, pd, pe, ab;
    logic [7:0]  heldByte;
    logic [1:0]  expStatus;
    logic [15:0] expBytes;
    case (mode)
      0:       begin expStatus = 2'd0; expBytes = 16'(n); end
      1:       begin expStatus = 2'd1; expBytes = 16'(n); end
      2:       begin expStatus = 2'd3; expBytes = 16'(n); end
      default: begin expStatus = 2'd2; expBytes = l;      end
    endcase
    @(negedge clk);
    start = 1'b1; base_addr = b; doc_len = l; abort = abortWithStart;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("busy_on_start", 32'(busy), 32'd1);
    xfers = 0; issues = 0; rstCnt = 0; cyc = 0; lastX = -1; doneCyc = 0;
    flagPend = 1'b0; holdPend = 1'b0; doneSeen = 1'b0; heldByte = 8'h00;
    while (!doneSeen && cyc < 3000) begin
      if (done) begin
        doneSeen = 1'b1;
        doneCyc  = cyc;
        par_ready = 1'b0; par_doc_end = 1'b0; par_error = 1'b0; abort = 1'b0; start = 1'b0;
        chk("status", 32'(status), 32'(expStatus));
        chk("bytes_consumed", 32'(bytes_consumed), 32'(expBytes));
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("valid_at_done", 32'(par_valid), 32'd0);
      end else begin
        if (holdPend) begin
          chk("hold_valid", 32'(par_valid), 32'd1);
          chk("hold_byte", 32'(par_byte), 32'(heldByte));
        end
        if (readyMode == 0)      pr = 1'b1;
        else if (readyMode == 1) pr = (cyc % 2 == 0);
        else                     pr = ($urandom_range(0, 3) != 0);
        pd = 1'b0; pe = 1'b0; ab = 1'b0;
        if (flagPend) begin
          pr = 1'b0;
          if (mode == 0) pd = 1'b1; else pe = 1'b1;
        end else if (mode == 2 && par_valid && xfers == n - 1) begin
          pr = 1'b1; ab = 1'b1;
        end
        par_ready = pr; par_doc_end = pd; par_error = pe; abort = ab;
        start     = busyStart && (cyc == 4);
        base_addr = busyStart ? 16'(b + 16'h0040) : b;
        doc_len   = busyStart ? 16'(l + 16'd3) : l;
        #1;
        xferNow = par_valid && par_ready;
        if (par_rst) rstCnt++;
        if (mem_en) begin
          chk("mem_addr", 32'(mem_addr), 32'(16'(b + issues)));
          issues++;
          chk("pending_le2", 32'((issues - xfers - int'(xferNow)) <= 2), 32'd1);
        end
        holdPend = par_valid && !par_ready && !(pd || pe || ab);
        heldByte = par_byte;
        if (xferNow) begin
          chk("byte", 32'(par_byte), 32'(memArr[16'(b + xfers)]));
          if (readyMode == 0 && lastX >= 0) chk("back_to_back", 32'(cyc - lastX), 32'd1);
          xfers++;
          lastX = cyc;
          if ((mode == 0 || mode == 1) && xfers == n) flagPend = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", 32'(doneSeen), 32'd1);
    chk("par_rst_cycles", 32'(rstCnt), (l == 16'd0) ? 32'd0 : 32'd1);
    if (l == 16'd0) chk("len0_mem_en", 32'(issues), 32'd0);
    if (mode == 3 && l != 16'd0) chk("drain_delay", 32'(doneCyc - lastX), 32'(DRAIN_TIMEOUT));
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_pulse", 32'(done), 32'd0);
    chk("status_held", 32'(status), 32'(expStatus));
    chk("bytes_held", 32'(bytes_consumed), 32'(expBytes));
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_status"}, 32'(status), 32'd0);
    chk({tag, "_bytes"}, 32'(bytes_consumed), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_par_rst"}, 32'(par_rst), 32'd0);
    chk({tag, "_par_byte"}, 32'(par_byte), 32'd0);
    chk({tag, "_par_valid"}, 32'(par_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) memArr[i] = 8'($urandom);
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; doc_len = '0;
    par_ready = 1'b0; par_doc_end = 1'b0; par_error = 1'b0;
    repeat (3) @(negedge clk);
    chkAllZero("reset");
    rst = 1'b0;

    runDoc(16'h0100, 16'd7,  0, 7, 0, 1'b0, 1'b0);
    runDoc(16'h0100, 16'd7,  0, 7, 1, 1'b0, 1'b0);
    runDoc(16'h0200, 16'd10, 1, 4, 0, 1'b0, 1'b0);
    runDoc(16'h0300, 16'd5,  3, 0, 0, 1'b0, 1'b0);
    runDoc(16'h0400, 16'd0,  3, 0, 0, 1'b0, 1'b0);
    runDoc(16'h0500, 16'd8,  2, 3, 0, 1'b0, 1'b0);
    runDoc(16'h0600, 16'd7,  0, 7, 0, 1'b1, 1'b1);
    runDoc(16'hFFFE, 16'd4,  0, 4, 0, 1'b0, 1'b0);
    runDoc(16'h0700, 16'd12, 0, 5, 1, 1'b0, 1'b0);

    // Reset in the middle of a document
    @(negedge clk);
    start = 1'b1; base_addr = 16'h0800; doc_len = 16'd20; par_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chkAllZero("midreset");
    rst = 1'b0;
    doneCnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    chk("no_done_after_reset", 32'(doneCnt), 32'd0);
    par_ready = 1'b0;

    for (int k = 0; k < 20; k++) begin
      int rl, rm, rn;
      rl = $urandom_range(1, 24);
      rm = $urandom_range(0, 3);
      rn = $urandom_range(1, rl);
      runDoc(16'($urandom), 16'(rl), rm, rn, 2, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/json_feed_sequencer.md
Name: json_feed_sequencer

Overview:
- Sequences the JSON parser for one document at a time: on command, fetches a byte range from document BRAM (1-cycle read latency) and streams it to the parser byte by byte under valid/ready flow control.
- Watches the parser's end-of-document and error flags, stops feeding when parsing ends, and reports a completion status and the count of bytes the parser accepted.
- Sits between the host/AXI control registers, the document BRAM and the parser core.

Parameters:
- ADDR_W, 16, BRAM byte-address width.
- LEN_W, 16, document length and byte-count width.
- DRAIN_TIMEOUT, 64, cycles to wait for par_doc_end after the last byte is accepted.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  launch request; sampled only in IDLE.
- abort  in  1  cancel the current document.
- base_addr  in  ADDR_W  first byte address; latched on accepted start.
- doc_len  in  LEN_W  byte count; latched on accepted start.
- busy  out  1  high from the accepted start until the done pulse, inclusive.
- done  out  1  one-cycle completion pulse.
- status  out  2  valid with done, held until the next start: 0 OK, 1 PARSE_ERR, 2 TRUNCATED, 3 ABORTED.
- bytes_consumed  out  LEN_W  parser-accepted byte count; valid with done, held until the next start.
- mem_en  out  1  BRAM read enable.
- mem_addr  out  ADDR_W  BRAM read address.
- mem_data  in  8  BRAM data; valid the cycle after mem_en.
- par_rst  out  1  one-cycle parser state clear.
- par_byte  out  8  byte to parser.
- par_valid  out  1  byte valid.
- par_ready  in  1  parser accepts the byte.
- par_doc_end  in  1  parser closed the root value.
- par_error  in  1  parser entered its Error state.

Behaviour:
- Reset: all outputs 0; state IDLE; counters and skid buffer cleared. Reset mid-document abandons it with no done pulse.
- A transfer occurs when par_valid && par_ready. bytes_consumed counts transfers.
- States:
  - IDLE: start=1 latches base_addr and doc_len, sets busy, clears counters, goes to CLEAR. If doc_len==0, it instead goes directly to DONE with TRUNCATED.
  - CLEAR: par_rst=1 for exactly one cycle, no mem_en, then STREAM.
  - STREAM:
    - Read issue: mem_en=1 when (buffered + in-flight) < 2 and issued < doc_len. mem_addr = base + issued (wraps modulo 2^ADDR_W).
    - Buffer: returning mem_data enters a 2-entry FIFO. par_byte/par_valid come from the FIFO head.
    - par_byte is stable while par_valid && !par_ready.
    - With par_ready held high, sustained throughput is 1 byte/cycle after a 2-cycle start latency (CLEAR, then the first read).
  - DRAIN: entered when transfers == doc_len. par_valid=0; a timer counts cycles.
  - DONE: done=1 for one cycle, busy=0 next cycle, then IDLE.
- Termination priority, evaluated every cycle in CLEAR/STREAM/DRAIN; the first match goes to DONE:
  1. abort → ABORTED.
  2. par_error → PARSE_ERR.
  3. par_doc_end → OK.
  4. DRAIN timer == DRAIN_TIMEOUT → TRUNCATED.
- A transfer in the same cycle as termination is counted.
- On termination, the FIFO is flushed and in-flight read data is discarded. No par_valid after the terminating cycle.
- par_doc_end before all bytes are sent means trailing bytes are not fed; status is OK with bytes_consumed < doc_len.
- start while busy is ignored. start and abort together in IDLE: start is accepted and abort is ignored.
- Counters are LEN_W wide; doc_len up to 2^LEN_W−1 is supported without overflow.

Test Plan:
- base=0x0100, len=7, par_ready=1, par_doc_end on the 7th transfer → par_rst 1 cycle; bytes from 0x0100..0x0106 in order on consecutive cycles; done, status=0, bytes_consumed=7.
- Same document, par_ready toggling 1-0-1-0 → par_byte held stable while not ready; no byte lost or duplicated; mem_en never leaves more than 2 bytes pending; bytes_consumed=7.
- len=10, par_error raised on the 4th transfer → par_valid low from the next cycle; status=1, bytes_consumed=4.
- len=5, no par_doc_end → all 5 bytes fed; done exactly 64 cycles after the last transfer; status=2. Separately, len=0 → done with status=2 and no mem_en or par_rst.
- abort during the 3rd byte with par_ready=1 → status=3, bytes_consumed=3. Separately, rst asserted mid-stream → all outputs 0 next cycle and no done pulse.
- start pulsed while busy → ignored; base=0xFFFE, len=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
